// File: rtl/xbus_pkg.sv
// Shared definitions for the XBUS master: widths, I/O page base and FSM states.
package xbus_pkg;

  localparam int ADDR_W = 22;
  localparam int DATA_W = 32;

  localparam logic [ADDR_W-1:0] IO_BASE = 22'o17772000;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_RECOVER = 2'd2
  } state_t;

endpackage

// File: rtl/xbus_if.sv
// XBUS bus-side signal bundle; master drives the request, slave answers.
interface xbus_if;
  import xbus_pkg::*;

  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] dataout;
  logic [DATA_W-1:0] datain;
  logic              req;
  logic              write;
  logic              decode;
  logic              ack;

  modport master (output addr, dataout, req, write, input datain, decode, ack);
  modport slave  (input addr, dataout, req, write, output datain, decode, ack);

endinterface

// File: rtl/xbus_timeout_ctr.sv
// No-device timeout counter: counts undecoded request cycles, flags the last one.
module xbus_timeout_ctr #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= 8'd0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  assign expired = (count == 8'(TIMEOUT - 1));

endmodule

// File: rtl/xbus_master.sv
// XBUS master: turns a CPU request into one bus transaction (IDLE/REQ/RECOVER).
// Optional no-device abort is built when XBUS_TIMEOUT_EN is defined.
module xbus_master
  import xbus_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_req,
  input  logic              cpu_write,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_err,
  output logic              busy,
  xbus_if.master            bus
);

  state_t state, state_nxt;
  logic   load_cmd;
  logic   finish;
  logic   abort;
  logic   timeout_hit;

`ifdef XBUS_TIMEOUT_EN
  logic decoded;
  logic expired;

  // Sticky claim flag; held clear outside REQ so every transaction starts fresh.
  always_ff @(posedge clk) begin
    if (reset || state != ST_REQ) begin
      decoded <= 1'b0;
    end else if (bus.decode) begin
      decoded <= 1'b1;
    end
  end

  xbus_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_timeout_ctr (
    .clk     (clk),
    .reset   (reset),
    .clear   (state != ST_REQ),
    .enable  (state == ST_REQ && !decoded && !bus.decode),
    .expired (expired)
  );

  assign timeout_hit = (state == ST_REQ) && expired && !decoded && !bus.decode;

  always_ff @(posedge clk) begin
    if (reset) begin
      cpu_err <= 1'b0;
    end else begin
      cpu_err <= abort;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign cpu_err     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:    if (cpu_req) state_nxt = ST_REQ;
      ST_REQ:     if (bus.ack || timeout_hit) state_nxt = ST_RECOVER;
      ST_RECOVER: if (!bus.ack) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // req follows the registered state directly, so reset drops it at the next edge.
  always_comb begin
    load_cmd = (state == ST_IDLE) && cpu_req;
    finish   = (state == ST_REQ) && (bus.ack || timeout_hit);
    abort    = timeout_hit && !bus.ack;
    bus.req  = (state == ST_REQ);
    busy     = (state != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.addr    <= '0;
      bus.dataout <= '0;
      bus.write   <= 1'b0;
      cpu_rdata   <= '0;
      cpu_done    <= 1'b0;
    end else begin
      cpu_done <= finish;
      if (load_cmd) begin
        bus.addr    <= cpu_addr;
        bus.dataout <= cpu_wdata;
        bus.write   <= cpu_write;
      end
      if (abort) begin
        cpu_rdata <= '0;
      end else if (finish && !bus.write) begin
        cpu_rdata <= bus.datain;
      end
    end
  end

endmodule
